ofs_plat_prim_burst_split_rsp_merge: RTL and testbench
======================================================

Name: ofs_plat_prim_burst_split_rsp_merge

Overview:
- Sits downstream of the burstcount0 mapping gearbox, on the response path of a split read channel.
- The gearbox turns one source burst into N sink bursts. This block records, per issued sink burst, whether it was the final piece of its source burst.
- On the returning in-order sink response stream, it rewrites the last-beat flag so that only the final beat of the final sink burst is marked last. The source therefore sees exactly one response burst per source request.
- It also tracks outstanding source bursts and flags protocol errors.

Parameters:
- DATA_WIDTH, 512, response payload width (passed through unmodified).
- MAX_ACTIVE_SINK_BURSTS, 64, depth of the split-tag FIFO; power of 2, minimum 2.
- SRC_CNT_WIDTH, 10, width of the outstanding-source-burst counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- sink_req_en  in  1  a sink burst is issued this cycle (gearbox s_accept_req qualified by sink acceptance)
- sink_req_is_last  in  1  issued piece completes its source burst (gearbox s_req_complete)
- sink_req_ready  out  1  tag FIFO can record a sink burst; upstream must not assert sink_req_en when low
- rsp_in_valid  in  1  sink response beat valid
- rsp_in_last  in  1  last beat of a sink burst
- rsp_in_data  in  DATA_WIDTH  sink response payload
- rsp_in_ready  out  1  beat accepted
- rsp_out_valid  out  1  source response beat valid
- rsp_out_last  out  1  last beat of a source burst
- rsp_out_data  out  DATA_WIDTH  payload
- rsp_out_ready  in  1  source consumer ready
- src_outstanding  out  SRC_CNT_WIDTH  source bursts issued but not yet returned
- err_underflow  out  1  sticky: response beat arrived with no recorded sink burst

Behaviour:
- Reset (asynchronous assert, release on clk): FIFO empty, src_outstanding=0, err_underflow=0.
  - Outputs during reset: sink_req_ready=0, rsp_in_ready=0, rsp_out_valid=0.
  - Reset mid-burst discards all tags; the source side is required to be reset simultaneously.
- Tag FIFO: one bit per entry, registered count and pointers.
  - sink_req_ready = !full. Computed from registered state only; a same-cycle pop never frees space for a same-cycle push.
  - Push when sink_req_en; push data = sink_req_is_last.
  - sink_req_en while full: ignored. Simulation assertion.
- Response datapath: zero-latency combinational pass-through.
  - rsp_out_valid = rsp_in_valid & !empty
  - rsp_in_ready = rsp_out_ready & !empty
  - rsp_out_data = rsp_in_data
  - rsp_out_last = rsp_in_last & head_tag
- No bypass on empty: a tag pushed in cycle t is usable for responses from cycle t+1.
- Pop: on a handshake (rsp_in_valid & rsp_in_ready) with rsp_in_last=1.
- Push and pop in the same cycle with a non-empty FIFO: count unchanged, both pointers advance.
- Pointers wrap modulo MAX_ACTIVE_SINK_BURSTS.
- src_outstanding:
  - +1 on push with sink_req_is_last=1.
  - -1 on pop with head_tag=1.
  - Both in the same cycle: unchanged.
  - Saturates at 0 and at all-ones; no wrap.
- err_underflow: set when rsp_in_valid=1 while empty for one cycle, and not yet set. Cleared only by reset.
- Responses are required to return in sink-request order; no reordering.

Decomposition:
- No shared package required; all widths derive locally from parameters.
- One natural sub-module: ofs_plat_prim_burst_split_tag_fifo.
  - Parameterised depth, 1-bit data, registered full/empty, async active-low reset.
  - Exposes head data, push, pop, full, empty.
- The top level holds the last-flag rewrite, the outstanding counter and the error logic.

Test Plan:
- Reset: hold reset_n=0 with rsp_in_valid=1 -> rsp_out_valid=0, sink_req_ready=0, src_outstanding=0. After release, sink_req_ready=1 next cycle.
- Split 1->3: push tags 0,0,1, then return 3 sink bursts of 4 beats (last on beats 4, 8, 12) -> 12 beats out, rsp_out_last only on beat 12. src_outstanding goes 1 then back to 0.
- No split: 5 pushes tag=1, 5 single-beat responses -> rsp_out_last=1 on every beat. src_outstanding peaks at 5, ends at 0.
- Full: MAX_ACTIVE_SINK_BURSTS=4, push 4 -> sink_req_ready=0. A pop in the same cycle as a 5th push request -> push still blocked that cycle, sink_req_ready=1 the next cycle.
- Backpressure: rsp_out_ready=0 for 3 cycles mid-burst -> rsp_in_ready=0, no pop, data held. Resume with no beat lost or duplicated.
- Underflow: rsp_in_valid=1 with FIFO empty -> rsp_in_ready=0 and err_underflow=1 from the next cycle. Stays set after later pushes until reset.

Source files
------------

// File: rtl/ofs_plat_prim_burst_split_tag_fifo.sv
// One-bit tag FIFO: each entry records whether an issued sink burst closes its source burst.
// Head data is read combinationally so the response path needs no extra pipeline stage.
module ofs_plat_prim_burst_split_tag_fifo #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head_data,
    output logic full,
    output logic empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic             mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             do_push;
    logic             do_pop;

    // Requests against full/empty are dropped here so the pointers can never overrun.
    assign do_push = push & ~full_reg;
    assign do_pop  = pop & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + 1'b1;
        else if (!do_push && do_pop)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_reg[wr_ptr_reg] <= push_data;
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign full      = full_reg;
    assign empty     = empty_reg;
endmodule

// File: rtl/ofs_plat_prim_burst_split_rsp_merge.sv
// Merges split sink response bursts back into one response burst per source request by
// masking rsp_in_last unless the head tag marks the final sink piece of its source burst.
module ofs_plat_prim_burst_split_rsp_merge #(
    parameter int DATA_WIDTH             = 512,
    parameter int MAX_ACTIVE_SINK_BURSTS = 64,
    parameter int SRC_CNT_WIDTH          = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sink_req_en,
    input  logic                     sink_req_is_last,
    output logic                     sink_req_ready,
    input  logic                     rsp_in_valid,
    input  logic                     rsp_in_last,
    input  logic [DATA_WIDTH-1:0]    rsp_in_data,
    output logic                     rsp_in_ready,
    output logic                     rsp_out_valid,
    output logic                     rsp_out_last,
    output logic [DATA_WIDTH-1:0]    rsp_out_data,
    input  logic                     rsp_out_ready,
    output logic [SRC_CNT_WIDTH-1:0] src_outstanding,
    output logic                     err_underflow
);
    logic                     active_reg;
    logic                     tag_full;
    logic                     tag_empty;
    logic                     head_tag;
    logic                     tag_push;
    logic                     tag_pop;
    logic                     src_inc;
    logic                     src_dec;
    logic [SRC_CNT_WIDTH-1:0] src_cnt_reg;
    logic                     err_underflow_reg;

    // Holds sink_req_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            active_reg <= 1'b0;
        else
            active_reg <= 1'b1;
    end

    assign sink_req_ready = active_reg & ~tag_full;
    assign tag_push       = sink_req_en & sink_req_ready;

    ofs_plat_prim_burst_split_tag_fifo #(
        .DEPTH(MAX_ACTIVE_SINK_BURSTS)
    ) tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (tag_push),
        .push_data(sink_req_is_last),
        .pop      (tag_pop),
        .head_data(head_tag),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    assign rsp_out_valid = rsp_in_valid & ~tag_empty;
    assign rsp_in_ready  = rsp_out_ready & ~tag_empty;
    assign rsp_out_data  = rsp_in_data;
    assign rsp_out_last  = rsp_in_last & head_tag;
    assign tag_pop       = rsp_in_valid & rsp_in_ready & rsp_in_last;

    assign src_inc = tag_push & sink_req_is_last;
    assign src_dec = tag_pop & head_tag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_cnt_reg       <= '0;
            err_underflow_reg <= 1'b0;
        end else begin
            if (src_inc && !src_dec && (src_cnt_reg != '1))
                src_cnt_reg <= src_cnt_reg + 1'b1;
            else if (src_dec && !src_inc && (src_cnt_reg != '0))
                src_cnt_reg <= src_cnt_reg - 1'b1;
            if (rsp_in_valid && tag_empty)
                err_underflow_reg <= 1'b1;
        end
    end

    assign src_outstanding = src_cnt_reg;
    assign err_underflow   = err_underflow_reg;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && sink_req_en)
            assert (sink_req_ready)
            else $error("sink_req_en asserted while the tag FIFO cannot accept");
    end
`endif
endmodule

// File: tb/tb_ofs_plat_prim_burst_split_rsp_merge.sv
// Directed bench: a tag model and a response scoreboard predict every output beat.
module tb_ofs_plat_prim_burst_split_rsp_merge;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sink_req_en;
    logic          sink_req_is_last;
    logic          sink_req_ready;
    logic          rsp_in_valid;
    logic          rsp_in_last;
    logic [DW-1:0] rsp_in_data;
    logic          rsp_in_ready;
    logic          rsp_out_valid;
    logic          rsp_out_last;
    logic [DW-1:0] rsp_out_data;
    logic          rsp_out_ready;
    logic [CW-1:0] src_outstanding;
    logic          err_underflow;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int model_out = 0;
    bit            tag_q[$];
    logic [DW:0]   sb[$];

    always #5 clk = ~clk;

    ofs_plat_prim_burst_split_rsp_merge #(
        .DATA_WIDTH(DW),
        .MAX_ACTIVE_SINK_BURSTS(DEPTH),
        .SRC_CNT_WIDTH(CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sink_req_en     (sink_req_en),
        .sink_req_is_last(sink_req_is_last),
        .sink_req_ready  (sink_req_ready),
        .rsp_in_valid    (rsp_in_valid),
        .rsp_in_last     (rsp_in_last),
        .rsp_in_data     (rsp_in_data),
        .rsp_in_ready    (rsp_in_ready),
        .rsp_out_valid   (rsp_out_valid),
        .rsp_out_last    (rsp_out_last),
        .rsp_out_data    (rsp_out_data),
        .rsp_out_ready   (rsp_out_ready),
        .src_outstanding (src_outstanding),
        .err_underflow   (err_underflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one sink burst; waits (bounded) for sink_req_ready.
    task automatic push_tag(input bit is_last);
        int n = 0;
        while (sink_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("push_ready_wait", 64'(n < 20), 64'd1);
        sink_req_en      = 1'b1;
        sink_req_is_last = is_last;
        @(negedge clk);
        sink_req_en      = 1'b0;
        tag_q.push_back(is_last);
        if (is_last) model_out++;
        $display("push tag=%0d src_outstanding_model=%0d", is_last, model_out);
    endtask

    // Send one response beat, optionally stalling rsp_out_ready for some cycles first.
    task automatic send_beat(input logic [DW-1:0] d, input bit last, input int stall);
        logic [DW:0] e;
        bit exp_last;
        bit t;
        exp_last = (tag_q.size() > 0) ? (last & tag_q[0]) : 1'b0;
        sb.push_back({exp_last, d});
        rsp_in_valid = 1'b1;
        rsp_in_data  = d;
        rsp_in_last  = last;
        for (int i = 0; i < stall; i++) begin
            rsp_out_ready = 1'b0;
            #1;
            check("bp_in_ready", 64'(rsp_in_ready), 64'd0);
            check("bp_data_held", 64'(rsp_out_data), 64'(d));
            @(negedge clk);
        end
        rsp_out_ready = 1'b1;
        #1;
        check("out_valid", 64'(rsp_out_valid), 64'd1);
        check("in_ready", 64'(rsp_in_ready), 64'd1);
        e = sb.pop_front();
        check("out_data", 64'(rsp_out_data), 64'(e[DW-1:0]));
        check("out_last", 64'(rsp_out_last), 64'(e[DW]));
        $display("beat data=%08h in_last=%0d out_last=%0d exp_last=%0d", d, last, rsp_out_last, e[DW]);
        @(negedge clk);
        rsp_in_valid = 1'b0;
        if (last && tag_q.size() > 0) begin
            t = tag_q.pop_front();
            if (t) model_out--;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; sink_req_en = 1'b0; sink_req_is_last = 1'b0;
        rsp_in_valid = 1'b1; rsp_in_last = 1'b0; rsp_in_data = '0; rsp_out_ready = 1'b1;

        // Reset behaviour
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(rsp_out_valid), 64'd0);
        check("rst_in_ready", 64'(rsp_in_ready), 64'd0);
        check("rst_sink_ready", 64'(sink_req_ready), 64'd0);
        check("rst_outstanding", 64'(src_outstanding), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);
        rsp_in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_sink_ready_same", 64'(sink_req_ready), 64'd0);
        @(negedge clk);
        check("rel_sink_ready_next", 64'(sink_req_ready), 64'd1);

        // Split 1 -> 3 sink bursts of 4 beats
        push_tag(1'b0); push_tag(1'b0); push_tag(1'b1);
        check("split_outstanding_1", 64'(src_outstanding), 64'(model_out));
        for (int i = 1; i <= 12; i++)
            send_beat(32'h1000 + 32'(i), (i % 4) == 0, 0);
        check("split_outstanding_0", 64'(src_outstanding), 64'(model_out));
        check("split_sb_empty", 64'(sb.size()), 64'd0);

        // No split: five single-beat source bursts
        for (int i = 0; i < 5; i++) push_tag(1'b1);
        check("nosplit_peak", 64'(src_outstanding), 64'd5);
        for (int i = 0; i < 5; i++) send_beat(32'h2000 + 32'(i), 1'b1, 0);
        check("nosplit_end", 64'(src_outstanding), 64'd0);

        // Full: pop in the pop cycle does not free space until the next cycle
        for (int i = 0; i < DEPTH; i++) push_tag(1'b1);
        check("full_ready_low", 64'(sink_req_ready), 64'd0);
        check("full_outstanding", 64'(src_outstanding), 64'(DEPTH));
        rsp_in_valid = 1'b1; rsp_in_last = 1'b1;
        #1;
        check("full_pop_cycle_ready", 64'(sink_req_ready), 64'd0);
        send_beat(32'h3000, 1'b1, 0);
        check("full_after_pop_ready", 64'(sink_req_ready), 64'd1);
        push_tag(1'b1);
        check("full_refill_ready", 64'(sink_req_ready), 64'd0);
        for (int i = 0; i < DEPTH; i++) send_beat(32'h3100 + 32'(i), 1'b1, 0);
        check("full_drain_outstanding", 64'(src_outstanding), 64'd0);

        // Backpressure mid-burst
        push_tag(1'b0); push_tag(1'b1);
        send_beat(32'hA001, 1'b0, 0);
        send_beat(32'hA002, 1'b0, 3);
        send_beat(32'hA003, 1'b1, 0);
        send_beat(32'hA004, 1'b0, 2);
        send_beat(32'hA005, 1'b1, 0);
        check("bp_outstanding", 64'(src_outstanding), 64'd0);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Underflow: beat with no recorded sink burst
        check("uf_err_before", 64'(err_underflow), 64'd0);
        rsp_in_valid = 1'b1; rsp_in_last = 1'b1; rsp_in_data = 32'hDEAD;
        #1;
        check("uf_in_ready", 64'(rsp_in_ready), 64'd0);
        check("uf_out_valid", 64'(rsp_out_valid), 64'd0);
        check("uf_err_same_cycle", 64'(err_underflow), 64'd0);
        @(negedge clk);
        rsp_in_valid = 1'b0;
        check("uf_err_set", 64'(err_underflow), 64'd1);
        push_tag(1'b1);
        check("uf_err_sticky", 64'(err_underflow), 64'd1);
        send_beat(32'hB000, 1'b1, 0);
        check("uf_err_sticky2", 64'(err_underflow), 64'd1);
        reset_n = 1'b0;
        #1;
        check("uf_err_reset", 64'(err_underflow), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
